// File: rtl/broaden_pulse_recover.sv
// Receive side of the pulse-broadening link: qualifies active runs of d by length,
// emits one q pulse per accepted run and queues events behind evt_vld/evt_rdy.
// Optional macro BROADEN_PULSE_RECOVER_INPUT_SYNC_EN adds a 2-flop synchronizer ahead of d_r.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no active run in progress
// QUAL  | run in progress, shorter than MIN_LEN so far (glitch if it ends)
// HOLD  | run accepted, waiting for it to end; flags runs longer than MAX_LEN
module broaden_pulse_recover #(
  parameter     PHASE   = "POSITIVE",
  parameter int MIN_LEN = 2,
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  output logic             q,
  output logic             evt_vld,
  input  logic             evt_rdy,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             len_err,
  output logic             ovf,
  input  logic             clr
);

  localparam logic INACT = (PHASE == "NEGATIVE") ? 1'b1 : 1'b0;
  // 9 bits hold MAX_LEN+1 for the largest legal MAX_LEN of 255.
  localparam int RUN_W = 9;
  localparam logic [RUN_W-1:0] MIN_V = RUN_W'(MIN_LEN);
  localparam logic [RUN_W-1:0] SAT_V = RUN_W'(MAX_LEN + 1);
  localparam logic [RUN_W-1:0] ONE_V = RUN_W'(1);
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {IDLE, QUAL, HOLD} state_t;

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] pend_cnt_q, pend_cnt_d;
  logic             d_r_q, d_r_d;
  logic             q_q, q_d;
  logic             len_err_q, len_err_d;
  logic             ovf_q, ovf_d;
  logic             d_in;
  logic             a;
  logic             accept;
  logic             len_set;
  logic             ovf_set;
  logic             pop;

`ifdef BROADEN_PULSE_RECOVER_INPUT_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= INACT;
      sync2_q <= INACT;
    end else begin
      sync1_q <= d;
      sync2_q <= sync1_q;
    end
  end

  assign d_in = sync2_q;
`else
  assign d_in = d;
`endif

  always_comb begin
    d_r_d     = d_in;
    a         = d_r_q ^ INACT;
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    accept    = 1'b0;
    len_set   = 1'b0;
    case (state_q)
      IDLE: begin
        run_cnt_d = '0;
        if (a) begin
          run_cnt_d = ONE_V;
          if (MIN_LEN == 1) begin
            accept  = 1'b1;
            state_d = HOLD;
          end else begin
            state_d = QUAL;
          end
        end
      end
      QUAL: begin
        if (!a) begin
          run_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          run_cnt_d = run_cnt_q + ONE_V;
          if (run_cnt_q + ONE_V == MIN_V) begin
            accept  = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (!a) begin
          run_cnt_d = '0;
          state_d   = IDLE;
        end else if (run_cnt_q != SAT_V) begin
          run_cnt_d = run_cnt_q + ONE_V;
          len_set   = (run_cnt_q + ONE_V == SAT_V);
        end
      end
      default: begin
        run_cnt_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  // An accept into a full queue with no simultaneous pop is dropped but still pulses q.
  always_comb begin
    pop        = (pend_cnt_q != '0) && evt_rdy;
    pend_cnt_d = pend_cnt_q;
    ovf_set    = 1'b0;
    case ({accept, pop})
      2'b10: begin
        if (pend_cnt_q == PEND_MAX) ovf_set = 1'b1;
        else pend_cnt_d = pend_cnt_q + 1'b1;
      end
      2'b01:   pend_cnt_d = pend_cnt_q - 1'b1;
      default: pend_cnt_d = pend_cnt_q;
    endcase
    q_d       = accept;
    len_err_d = len_set | (len_err_q & ~clr);
    ovf_d     = ovf_set | (ovf_q & ~clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      run_cnt_q  <= '0;
      pend_cnt_q <= '0;
      d_r_q      <= INACT;
      q_q        <= 1'b0;
      len_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_cnt_q  <= run_cnt_d;
      pend_cnt_q <= pend_cnt_d;
      d_r_q      <= d_r_d;
      q_q        <= q_d;
      len_err_q  <= len_err_d;
      ovf_q      <= ovf_d;
    end
  end

  assign q        = q_q;
  assign evt_vld  = (pend_cnt_q != '0);
  assign pend_cnt = pend_cnt_q;
  assign len_err  = len_err_q;
  assign ovf      = ovf_q;

endmodule

// File: doc/broaden_pulse_recover.md
Name: broaden_pulse_recover

Overview:
- Receive-side counterpart to the pulse-broadening transmit path.
- Takes a stretched pulse stream that has already been brought into the local clock domain and qualifies each asserted run by its length.
- Emits exactly one single-cycle pulse per accepted run.
- Queues accepted events behind a valid/ready handshake so a slow consumer loses none, up to a counter limit; length errors and overflow are flagged sticky.

Parameters:
PHASE, "POSITIVE", asserted polarity of d: "POSITIVE" means active-high, "NEGATIVE" means active-low.
MIN_LEN, 2, minimum consecutive active samples for a run to be accepted as an event (range 1..255).
MAX_LEN, 16, maximum legal consecutive active samples; longer runs set len_err (MAX_LEN >= MIN_LEN, at most 255).
CNT_W, 4, width of the pending-event counter.

Ports:
clk  input  1  sole clock.
rst  input  1  synchronous, active-high reset.
d  input  1  broadened pulse stream, already synchronous to clk.
q  output  1  one-cycle pulse per accepted event.
evt_vld  output  1  at least one event is pending.
evt_rdy  input  1  consumer takes one pending event when evt_vld=1.
pend_cnt  output  CNT_W  number of pending events.
len_err  output  1  sticky: a run exceeded MAX_LEN.
ovf  output  1  sticky: an event was dropped because pend_cnt was saturated.
clr  input  1  clears len_err and ovf.

Behaviour:
- Input register d_r samples d on every edge.
  - Reset value of d_r is the inactive level: 0 for POSITIVE, 1 for NEGATIVE.
  - a = d_r when PHASE is POSITIVE, ~d_r when NEGATIVE.
- run_cnt counts consecutive cycles with a=1, saturating at MAX_LEN+1. It is cleared on any cycle with a=0.
- State machine:
  - IDLE: if a=1, run_cnt<=1; if MIN_LEN=1, go to HOLD and accept; otherwise go to QUAL.
  - QUAL: if a=0, the run is a glitch; drop it and go to IDLE. If a=1 and run_cnt+1==MIN_LEN, accept and go to HOLD. Otherwise stay.
  - HOLD: if a=0, go to IDLE. If a=1 and run_cnt reaches MAX_LEN+1, set len_err and stay in HOLD until a=0.
- Accept timing: q=1 for exactly one cycle, registered.
  - If d is first sampled active at edge E0, q is high in the cycle after edge E0+MIN_LEN.
  - For MIN_LEN=1, q is high after edge E0+1.
- A run produces at most one event regardless of its length.
- Adjacent pulses with no inactive sample between them merge into one event. This is a documented limitation; the transmit side must guarantee a gap.
- pend_cnt update (on the same edge that raises q):
  - Accept only: +1.
  - Pop only (evt_vld && evt_rdy): -1.
  - Accept and pop in the same cycle: unchanged.
- Overflow: an accept when pend_cnt = 2^CNT_W-1 and no pop is dropped. pend_cnt is unchanged, ovf is set, and q still pulses.
- evt_vld = (pend_cnt != 0), combinational from the register. evt_rdy with evt_vld=0 is ignored.
- Sticky flags: clr clears len_err and ovf. If a set condition and clr occur in the same cycle, set wins.
- Reset: state=IDLE, run_cnt=0, q=0, pend_cnt=0, evt_vld=0, len_err=0, ovf=0, d_r=inactive level.
  - Reset mid-run discards the run.
  - After reset is released while d is still active, the remainder of that run is qualified as a fresh run starting from run_cnt=1.

Optional Feature:
- Macro BROADEN_PULSE_RECOVER_INPUT_SYNC_EN.
- When defined:
  - d passes through a 2-flop synchronizer ahead of d_r, both flops reset to the inactive level.
  - d may be asynchronous.
  - All input-to-q latencies grow by 2 cycles.
- When undefined: d feeds d_r directly; latency is as stated above.

Test Plan:
- Defaults, POSITIVE. d=1 for 5 cycles then 0, evt_rdy=0 -> one q pulse at edge E0+2; pend_cnt=1; evt_vld=1; len_err=0.
- d=1 for 1 cycle (glitch, MIN_LEN=2) -> no q; pend_cnt stays 0. Then d=1 for 2 cycles -> one q; pend_cnt=1.
- d=1 for 20 cycles (MAX_LEN=16) -> one q; len_err=1 after the 17th active sample. clr pulsed after d returns to 0 -> len_err=0.
- CNT_W=4, evt_rdy=0, 16 separated 5-cycle runs -> 16 q pulses; pend_cnt saturates at 15; ovf=1. Then evt_rdy=1 for 15 cycles -> pend_cnt=0, evt_vld=0.
- Accept coinciding with a pop while pend_cnt=3 -> pend_cnt stays 3. rst asserted mid-run on a 10-cycle run -> all outputs 0 next cycle; the run tail still active after release is counted as new and yields q once MIN_LEN samples are seen.
- PHASE="NEGATIVE", d idle 1, low for 4 cycles -> one q pulse. Repeat with BROADEN_PULSE_RECOVER_INPUT_SYNC_EN defined -> q arrives 2 cycles later.
